// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
// - Default operand and segment widths.
// - Segment/stage count helper.
// - Bit indices of the internal flag vector.
package adder_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefSegW  = 8;

  // Flag vector bit positions
  localparam int unsigned CARRY    = 0;
  localparam int unsigned OVF      = 1;
  localparam int unsigned ZERO     = 2;
  localparam int unsigned NEG      = 3;
  localparam int unsigned NumFlags = 4;

  // Number of segments, which is also the number of stages and the latency.
  function automatic int unsigned calc_nseg(input int unsigned width, input int unsigned seg_w);
    return width / seg_w;
  endfunction

endpackage

// File: rtl/adder_seg_stage.sv
// One segment of the pipelined adder: adds two SEG_W-bit operand slices plus a
// carry-in and registers the partial sum, carry-out and the stage valid bit.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   hold_i            keep all registers unchanged (global stall)
//   valid_i           operation entering this stage is valid
//   a_i, b_i          operand slices (b_i already inverted for subtraction)
//   carry_i           carry into this segment
//   valid_o           registered valid bit
//   sum_o             registered SEG_W-bit partial sum
//   carry_o           registered carry-out of this segment
module adder_seg_stage #(
  parameter int unsigned SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold_i,
  input  logic             valid_i,
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic             carry_i,
  output logic             valid_o,
  output logic [SEG_W-1:0] sum_o,
  output logic             carry_o
);

  logic [SEG_W:0]   add;
  logic             valid_q;
  logic [SEG_W-1:0] sum_q;
  logic             carry_q;

  assign add = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, carry_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (!hold_i) begin
      valid_q <= valid_i;
      sum_q   <= add[SEG_W-1:0];
      carry_q <= add[SEG_W];
    end
  end

  assign valid_o = valid_q;
  assign sum_o   = sum_q;
  assign carry_o = carry_q;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit. A WIDTH-bit operation is split into NSEG
// segments of SEG_W bits, one per stage, with the carry rippling through the
// stage registers. Latency NSEG, throughput one operation per cycle, global
// stall on output backpressure.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid_i / in_ready_o     input handshake (in_ready_o = !stall)
//   a_i, b_i, sub_i             operands and mode (0: a+b, 1: a-b)
//   out_valid_o / out_ready_i   output handshake
//   result_o                    sum or difference modulo 2^WIDTH
//   carry_o                     MSB carry-out (1 = no borrow for subtraction)
//   overflow_o                  two's-complement overflow
//   zero_o, negative_o          result == 0, result MSB
module adder_pipe
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned SEG_W    = DefSegW,
  parameter bit          FLAGS_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             zero_o,
  output logic             negative_o
);

  localparam int unsigned NSEG = calc_nseg(WIDTH, SEG_W);

  if (WIDTH == 0 || SEG_W == 0 || (WIDTH % SEG_W) != 0) begin : g_bad_params
    $error("adder_pipe: WIDTH must be a non-zero multiple of SEG_W");
  end

  logic                stall;
  logic [WIDTH-1:0]    b_inv;
  logic [SEG_W-1:0]    seg_a   [NSEG];
  logic [SEG_W-1:0]    seg_b   [NSEG];
  logic [SEG_W-1:0]    seg_sum [NSEG];
  logic [NSEG-1:0]     seg_cin;
  logic [NSEG-1:0]     seg_cout;
  logic [NSEG-1:0]     seg_vin;
  logic [NSEG-1:0]     seg_vout;
  // Bank k travels alongside stage k. Only [k][j>k] of the operand banks and
  // [k][j<k] of the result bank are ever written or read.
  logic [SEG_W-1:0]    opa_q   [NSEG][NSEG];
  logic [SEG_W-1:0]    opb_q   [NSEG][NSEG];
  logic [SEG_W-1:0]    res_q   [NSEG][NSEG];
  logic [NSEG-1:0]     msb_a_q;
  logic [NSEG-1:0]     msb_b_q;
  logic [WIDTH-1:0]    result;
  logic [NumFlags-1:0] flags;

  // Subtraction as a + ~b + 1; the +1 enters as stage 0 carry-in.
  assign b_inv = sub_i ? ~b_i : b_i;

  assign out_valid_o = seg_vout[NSEG-1];
  assign stall       = seg_vout[NSEG-1] & ~out_ready_i;
  assign in_ready_o  = ~stall;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign seg_a[k]   = a_i[SEG_W-1:0];
      assign seg_b[k]   = b_inv[SEG_W-1:0];
      assign seg_cin[k] = sub_i;
      assign seg_vin[k] = in_valid_i;
    end else begin : g_next
      assign seg_a[k]   = opa_q[k-1][k];
      assign seg_b[k]   = opb_q[k-1][k];
      assign seg_cin[k] = seg_cout[k-1];
      assign seg_vin[k] = seg_vout[k-1];
    end

    adder_seg_stage #(
      .SEG_W(SEG_W)
    ) u_seg (
      .clk    (clk),
      .rst_n  (rst_n),
      .hold_i (stall),
      .valid_i(seg_vin[k]),
      .a_i    (seg_a[k]),
      .b_i    (seg_b[k]),
      .carry_i(seg_cin[k]),
      .valid_o(seg_vout[k]),
      .sum_o  (seg_sum[k]),
      .carry_o(seg_cout[k])
    );
  end

  // Skew (pending operand segments) and deskew (finished result segments).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NSEG; k++) begin
        for (int unsigned j = 0; j < NSEG; j++) begin
          opa_q[k][j] <= '0;
          opb_q[k][j] <= '0;
          res_q[k][j] <= '0;
        end
      end
      msb_a_q <= '0;
      msb_b_q <= '0;
    end else if (!stall) begin
      for (int unsigned k = 0; k < NSEG; k++) begin
        for (int unsigned j = 0; j < NSEG; j++) begin
          if (k == 0) begin
            if (j > 0) begin
              opa_q[k][j] <= a_i[j*SEG_W +: SEG_W];
              opb_q[k][j] <= b_inv[j*SEG_W +: SEG_W];
            end
          end else if (j > k) begin
            opa_q[k][j] <= opa_q[k-1][j];
            opb_q[k][j] <= opb_q[k-1][j];
          end else if (j + 1 == k) begin
            res_q[k][j] <= seg_sum[j];
          end else if (j < k) begin
            res_q[k][j] <= res_q[k-1][j];
          end
        end
      end
      msb_a_q[0] <= a_i[WIDTH-1];
      msb_b_q[0] <= b_inv[WIDTH-1];
      for (int unsigned k = 1; k < NSEG; k++) begin
        msb_a_q[k] <= msb_a_q[k-1];
        msb_b_q[k] <= msb_b_q[k-1];
      end
    end
  end

  always_comb begin
    result = '0;
    for (int unsigned j = 0; j + 1 < NSEG; j++) begin
      result[j*SEG_W +: SEG_W] = res_q[NSEG-1][j];
    end
    result[(NSEG-1)*SEG_W +: SEG_W] = seg_sum[NSEG-1];
  end

  // Flags are decoded from final-stage registers only.
  always_comb begin
    flags = '0;
    if (FLAGS_EN) begin
      flags[CARRY] = seg_cout[NSEG-1];
      flags[OVF]   = (msb_a_q[NSEG-1] == msb_b_q[NSEG-1]) &&
                     (result[WIDTH-1] != msb_a_q[NSEG-1]);
      // Gated so an idle (cleared) result does not report zero.
      flags[ZERO]  = seg_vout[NSEG-1] && ~|result;
      flags[NEG]   = result[WIDTH-1];
    end
  end

  assign result_o   = result;
  assign carry_o    = flags[CARRY];
  assign overflow_o = flags[OVF];
  assign zero_o     = flags[ZERO];
  assign negative_o = flags[NEG];

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: directed vectors, reset drop, backpressure and random
// streams on 32/8, 64/16 and 32/32 instances against an arithmetic model.
module tb_adder_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 32-bit, 8-bit segments
  logic        in_valid, in_ready, sub, out_valid, out_ready;
  logic        carry, overflow, zero, negative;
  logic [31:0] a, b, result;
  // 64-bit, 16-bit segments
  logic        w_in_valid, w_in_ready, w_sub, w_out_valid, w_out_ready;
  logic        w_carry, w_overflow, w_zero, w_negative;
  logic [63:0] w_a, w_b, w_result;
  // 32-bit, single stage
  logic        s_in_valid, s_in_ready, s_sub, s_out_valid, s_out_ready;
  logic        s_carry, s_overflow, s_zero, s_negative;
  logic [31:0] s_a, s_b, s_result;

  adder_pipe #(.WIDTH(32), .SEG_W(8), .FLAGS_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .sub_i(sub), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .carry_o(carry), .overflow_o(overflow), .zero_o(zero),
    .negative_o(negative)
  );

  adder_pipe #(.WIDTH(64), .SEG_W(16), .FLAGS_EN(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid_i(w_in_valid), .in_ready_o(w_in_ready),
    .a_i(w_a), .b_i(w_b), .sub_i(w_sub), .out_valid_o(w_out_valid),
    .out_ready_i(w_out_ready), .result_o(w_result), .carry_o(w_carry),
    .overflow_o(w_overflow), .zero_o(w_zero), .negative_o(w_negative)
  );

  adder_pipe #(.WIDTH(32), .SEG_W(32), .FLAGS_EN(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
    .a_i(s_a), .b_i(s_b), .sub_i(s_sub), .out_valid_o(s_out_valid),
    .out_ready_i(s_out_ready), .result_o(s_result), .carry_o(s_carry),
    .overflow_o(s_overflow), .zero_o(s_zero), .negative_o(s_negative)
  );

  typedef struct packed {
    logic [63:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } exp_t;

  // f = {negative, zero, overflow, carry}
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  vec_t dirv [7] = '{
    '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 4'b0000},
    '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 4'b0000},
    '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b0101},
    '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b1010},
    '{32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 4'b0001},
    '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 4'b1000},
    '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b0011}
  };

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   got_main;
  exp_t q_main [$];
  exp_t q_w    [$];
  exp_t q_s    [$];

  // Reference: plain w-bit modular arithmetic and textbook signed overflow.
  function automatic exp_t ref_op(input logic [63:0] av, input logic [63:0] bv, input logic s,
                                  input int unsigned w);
    logic [64:0] mask, ae, be, full;
    exp_t e;
    mask  = (65'd1 << w) - 65'd1;
    ae    = {1'b0, av} & mask;
    be    = {1'b0, bv} & mask;
    full  = s ? (ae - be) : (ae + be);
    e.res = full[63:0] & mask[63:0];
    e.c   = s ? (ae >= be) : full[w];
    e.n   = e.res[w-1];
    e.z   = (e.res == 64'd0);
    if (s) e.v = (ae[w-1] != be[w-1]) && (e.n != ae[w-1]);
    else   e.v = (ae[w-1] == be[w-1]) && (e.n != ae[w-1]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e, input logic [63:0] r, input logic c,
                         input logic v, input logic z, input logic n);
    chk({tag, ".result"},   r,      e.res);
    chk({tag, ".carry"},    64'(c), 64'(e.c));
    chk({tag, ".overflow"}, 64'(v), 64'(e.v));
    chk({tag, ".zero"},     64'(z), 64'(e.z));
    chk({tag, ".negative"}, 64'(n), 64'(e.n));
  endtask

  // One cycle of the 32/8 instance, entered and left at a falling edge.
  task automatic step(input logic iv, input logic [31:0] av, input logic [31:0] bv,
                      input logic sv, input logic ordy, input string tag);
    logic exp_rdy;
    if (out_valid) begin
      if (q_main.size() == 0) chk({tag, ".spurious_out"}, 64'(out_valid), 64'd0);
      else chk_out(tag, q_main[0], {32'd0, result}, carry, overflow, zero, negative);
    end
    in_valid  = iv;
    a         = av;
    b         = bv;
    sub       = sv;
    out_ready = ordy;
    #1;
    exp_rdy = !(out_valid && !ordy);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    if (out_valid && ordy && q_main.size() > 0) begin
      void'(q_main.pop_front());
      got_main++;
    end
    if (iv && exp_rdy) q_main.push_back(ref_op({32'd0, av}, {32'd0, bv}, sv, 32));
    @(negedge clk);
  endtask

  initial begin
    exp_t        e;
    int          issued;
    int          stall_left;
    logic        ordy;
    logic        acc;
    logic [31:0] ra, rb;
    logic        rs;

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_a = '0; w_b = '0; w_sub = 1'b0; w_out_ready = 1'b1;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_sub = 1'b0; s_out_ready = 1'b1;
    got_main = 0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.result",    {32'd0, result}, 64'd0);
    chk("reset.flags",     64'({negative, zero, overflow, carry}), 64'd0);
    chk("reset.in_ready",  64'(in_ready), 64'd1);
    chk("reset.w_out_valid", 64'(w_out_valid), 64'd0);
    chk("reset.s_out_valid", 64'(s_out_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors with latency check
    for (int k = 0; k < 7; k++) begin
      step(1'b1, dirv[k].a, dirv[k].b, dirv[k].s, 1'b1, $sformatf("dir%0d", k));
      for (int i = 1; i < 4; i++) begin
        chk($sformatf("dir%0d.early_valid", k), 64'(out_valid), 64'd0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, $sformatf("dir%0d", k));
      end
      chk($sformatf("dir%0d.out_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("dir%0d.const_result", k), {32'd0, result}, {32'd0, dirv[k].r});
      chk($sformatf("dir%0d.const_flags", k), 64'({negative, zero, overflow, carry}),
          64'(dirv[k].f));
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, $sformatf("dir%0d", k));
    end

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, $urandom, 1'b0, 1'b1, "rst_fill");
    rst_n = 1'b0;
    #1;
    chk("rst_mid.out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid.result",    {32'd0, result}, 64'd0);
    chk("rst_mid.flags",     64'({negative, zero, overflow, carry}), 64'd0);
    chk("rst_mid.in_ready",  64'(in_ready), 64'd1);
    q_main.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("rst_mid.dropped", 64'(out_valid), 64'd0);
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, "rst_idle");
    end

    // Backpressure: 8 ops, 5-cycle stall from the first valid result
    issued = 0;
    stall_left = -1;
    got_main = 0;
    for (int cyc = 0; cyc < 60 && got_main < 8; cyc++) begin
      ordy = 1'b1;
      if (stall_left < 0 && out_valid) stall_left = 5;
      if (stall_left > 0) begin
        ordy = 1'b0;
        stall_left--;
        chk("bp.hold_valid", 64'(out_valid), 64'd1);
      end
      acc = (issued < 8) && !(out_valid && !ordy);
      step(issued < 8, $urandom, $urandom, 1'($urandom_range(0, 1)), ordy, "bp");
      if (acc) issued++;
    end
    chk("bp.delivered", 64'(got_main), 64'd8);
    chk("bp.leftover",  64'(q_main.size()), 64'd0);
    chk("bp.stall_seen", 64'(stall_left), 64'd0);

    // Random streams on all three instances, continuous valid and ready
    for (int i = 0; i <= 104; i++) begin
      chk("rnd64.out_valid", 64'(w_out_valid), 64'(i >= 4 && i < 104));
      if (w_out_valid && q_w.size() > 0) begin
        e = q_w.pop_front();
        chk_out("rnd64", e, w_result, w_carry, w_overflow, w_zero, w_negative);
      end
      chk("rnd1.out_valid", 64'(s_out_valid), 64'(i >= 1 && i < 101));
      if (s_out_valid && q_s.size() > 0) begin
        e = q_s.pop_front();
        chk_out("rnd1", e, {32'd0, s_result}, s_carry, s_overflow, s_zero, s_negative);
      end
      w_in_valid = (i < 100);
      w_a   = {$urandom, $urandom};
      w_b   = (i % 10 == 3) ? w_a : {$urandom, $urandom};
      w_sub = $urandom_range(0, 1) == 1;
      s_in_valid = (i < 100);
      s_a   = (i % 10 == 7) ? 32'hFFFF_FFFF : $urandom;
      s_b   = (i % 10 == 5) ? s_a : $urandom;
      s_sub = $urandom_range(0, 1) == 1;
      #1;
      chk("rnd64.in_ready", 64'(w_in_ready), 64'd1);
      chk("rnd1.in_ready",  64'(s_in_ready), 64'd1);
      if (w_in_valid) q_w.push_back(ref_op(w_a, w_b, w_sub, 64));
      if (s_in_valid) q_s.push_back(ref_op({32'd0, s_a}, {32'd0, s_b}, s_sub, 32));
      chk("rnd32.out_valid", 64'(out_valid), 64'(i >= 4 && i < 104));
      ra = $urandom;
      rb = (i % 10 == 1) ? ra : $urandom;
      rs = $urandom_range(0, 1) == 1;
      step(i < 100, ra, rb, rs, 1'b1, "rnd32");
    end
    chk("rnd32.leftover", 64'(q_main.size()), 64'd0);
    chk("rnd64.leftover", 64'(q_w.size()), 64'd0);
    chk("rnd1.leftover",  64'(q_s.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
